// File: rtl/tpu_pkg.sv
// tpu_pkg: shared scheduler state encoding and job beat counts
package tpu_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, READ, DRAIN} sched_state_t;
  localparam int N_OPERAND_BEATS = 8;
  localparam int N_RESULT_BEATS = 4;
endpackage

// File: rtl/mmu_job_arbiter_if.sv
// mmu_job_arbiter_if: host-side job handshakes plus the engine load/read port
interface mmu_job_arbiter_if;
  logic [1:0] req, gnt, op_valid, op_ready, rsp_valid, rsp_ready;
  logic [15:0] op_data;
  logic [7:0] rsp_data, eng_in_data, eng_out_data;
  logic eng_load_en, eng_load_sel_ab, eng_output_en, eng_done;
  logic [1:0] eng_load_index, eng_output_sel;
  modport master (
    output req, op_valid, op_data, rsp_ready, eng_out_data, eng_done,
    input gnt, op_ready, rsp_valid, rsp_data, eng_load_en, eng_load_sel_ab, eng_load_index,
          eng_in_data, eng_output_en, eng_output_sel
  );
  modport slave (
    input req, op_valid, op_data, rsp_ready, eng_out_data, eng_done,
    output gnt, op_ready, rsp_valid, rsp_data, eng_load_en, eng_load_sel_ab, eng_load_index,
           eng_in_data, eng_output_en, eng_output_sel
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin picker remembering the last served requester
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic [1:0] grant
);
  logic last_q, last_d;
  // on contention pick the requester that was not served last
  always_comb begin
    last_d = update ? last : last_q;
    grant = &req ? (last_q ? 2'b01 : 2'b10) : req;
  end
  // reset pretends requester 1 was served so requester 0 wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/mmu_job_arbiter.sv
// mmu_job_arbiter: shares one 2x2 matmul engine between two job requesters
module mmu_job_arbiter
  import tpu_pkg::*;
#(
  parameter int ENG_LATENCY  = 8,
  parameter int DONE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  mmu_job_arbiter_if.slave io,
  output logic             busy,
  output logic             err_timeout
);
  localparam int CW = $clog2(ENG_LATENCY);
  localparam int TW = $clog2(DONE_TIMEOUT);
  sched_state_t state_q, state_d;
  logic [1:0] gnt_q, gnt_d, arb_gnt;
  logic [2:0] beat_q, beat_d;
  logic [1:0] rbeat_q, rbeat_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic err_q, err_d;
  logic g, op_hs, rsp_hs, done_exit;
  rr_arbiter2 u_arb (
    .clk(clk),
    .rst(rst),
    .req(io.req),
    .update(done_exit),
    .last(g),
    .grant(arb_gnt)
  );
  // route handshakes to the granted requester only; everything idles at zero outside its state
  always_comb begin
    g = gnt_q[1];
    op_hs = state_q == LOAD && io.op_valid[g];
    rsp_hs = state_q == READ && io.rsp_ready[g];
    done_exit = state_q == DRAIN && (io.eng_done || tmr_q == TW'(DONE_TIMEOUT - 1));
    io.gnt = gnt_q;
    io.op_ready = state_q == LOAD ? gnt_q : 2'b00;
    io.rsp_valid = state_q == READ ? gnt_q : 2'b00;
    io.rsp_data = state_q == READ ? io.eng_out_data : 8'h00;
    io.eng_load_en = op_hs;
    io.eng_load_sel_ab = state_q == LOAD && beat_q[2];
    io.eng_load_index = state_q == LOAD ? beat_q[1:0] : 2'b00;
    io.eng_in_data = state_q == LOAD ? io.op_data[{g, 3'b000} +: 8] : 8'h00;
    io.eng_output_en = rsp_hs;
    io.eng_output_sel = state_q == READ ? rbeat_q : 2'b00;
    busy = state_q != IDLE;
    err_timeout = err_q;
  end
  // job sequencing; every counter's terminal value forces the state change
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    beat_d = beat_q;
    rbeat_d = rbeat_q;
    cnt_d = cnt_q;
    tmr_d = tmr_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        beat_d = '0;
        rbeat_d = '0;
        if (|io.req) begin
          gnt_d = arb_gnt;
          state_d = LOAD;
        end
      end
      LOAD: if (op_hs) begin
        beat_d = beat_q == 3'(N_OPERAND_BEATS - 1) ? 3'd0 : beat_q + 3'd1;
        if (beat_q == 3'(N_OPERAND_BEATS - 1)) begin
          state_d = COMPUTE;
          cnt_d = CW'(ENG_LATENCY - 1);
        end
      end
      COMPUTE: begin
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
        if (cnt_q == '0) state_d = READ;
      end
      READ: if (rsp_hs) begin
        rbeat_d = rbeat_q == 2'(N_RESULT_BEATS - 1) ? 2'd0 : rbeat_q + 2'd1;
        if (rbeat_q == 2'(N_RESULT_BEATS - 1)) begin
          state_d = DRAIN;
          tmr_d = '0;
        end
      end
      DRAIN: begin
        tmr_d = done_exit ? '0 : tmr_q + TW'(1);
        err_d = err_q | (done_exit & ~io.eng_done);
        if (done_exit) begin
          state_d = IDLE;
          gnt_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // all scheduler state, cleared asynchronously together with the engine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= 2'b00;
      beat_q <= '0;
      rbeat_q <= '0;
      cnt_q <= '0;
      tmr_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      beat_q <= beat_d;
      rbeat_q <= rbeat_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
      err_q <= err_d;
    end
  end
endmodule
